// File: rtl/tqvp_nkanderson_wdt_resetctl_pkg.sv
// Shared definitions for the TinyQV watchdog peripherals: register map, ACK key,
// escalation FSM states and bus transfer-size codes.
package tqvp_nkanderson_wdt_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_GRACE  = 6'd1;
    localparam logic [5:0] ADDR_PULSE  = 6'd2;
    localparam logic [5:0] ADDR_ACK    = 6'd3;
    localparam logic [5:0] ADDR_STATUS = 6'd4;
    localparam logic [5:0] ADDR_EVENTS = 6'd5;

    localparam logic [31:0] ACK_MAGIC = 32'h0000_005A;

    localparam logic [1:0] XFER_8    = 2'b00;
    localparam logic [1:0] XFER_16   = 2'b01;
    localparam logic [1:0] XFER_32   = 2'b10;
    localparam logic [1:0] XFER_NONE = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WARN  = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3
    } wdtrc_state_e;

endpackage

// File: rtl/tqvp_nkanderson_wdt_resetctl_if.sv
// TinyQV peripheral register bus; the CPU side is master, the peripheral is slave.
interface tqvp_nkanderson_wdt_resetctl_if;

    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );

endinterface

// File: rtl/tqvp_nkanderson_wdt_resetctl.sv
// Watchdog escalation stage: timeout -> interrupt + grace window -> timed reset pulse on uo_out[1].
// Optional macro WDTRC_EXT_FAULT_EN adds ui_in[6] as an external fault trigger.
module tqvp_nkanderson_wdt_resetctl
    import tqvp_nkanderson_wdt_pkg::*;
#(
    parameter int unsigned GRACE_W       = 16,
    parameter int unsigned PULSE_W       = 8,
    parameter int unsigned PULSE_DEFAULT = 16,
    parameter int unsigned EVT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wdt_timeout,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    output logic       user_interrupt,
    tqvp_nkanderson_wdt_resetctl_if.slave bus
);

    wdtrc_state_e       state_q, state_d;
    logic [GRACE_W-1:0] gcnt_q, gcnt_d, grace_q, grace_d;
    logic [PULSE_W-1:0] pcnt_q, pcnt_d, pulse_q, pulse_d;
    logic [EVT_W-1:0]   events_q, events_d;
    logic               rst_req_q, rst_req_d;
    logic               irq_q, irq_d;
    logic               caused_q, caused_d;
    logic               enable_q, enable_d;
    logic               lock_q, lock_d;

    logic               ext_fault;
    logic               trig;
    logic               wr_en;
    logic               rd_en;
    logic               ack;
    logic [31:0]        wdata;

`ifdef WDTRC_EXT_FAULT_EN
    assign ext_fault = ui_in[6];
`else
    logic unused_ui;
    assign ext_fault = 1'b0;
    assign unused_ui = ^ui_in;
`endif

    assign trig  = wdt_timeout | ext_fault;
    assign wr_en = bus.data_write_n != XFER_NONE;
    assign rd_en = bus.data_read_n != XFER_NONE;
    assign ack   = wr_en && (bus.address == ADDR_ACK) && (bus.data_in == ACK_MAGIC);

    // Narrow writes zero-extend into the target register.
    always_comb begin
        case (bus.data_write_n)
            XFER_8:  wdata = {24'd0, bus.data_in[7:0]};
            XFER_16: wdata = {16'd0, bus.data_in[15:0]};
            default: wdata = bus.data_in;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        pcnt_d    = pcnt_q;
        events_d  = events_q;
        rst_req_d = rst_req_q;
        irq_d     = irq_q;
        caused_d  = caused_q;
        enable_d  = enable_q;
        lock_d    = lock_q;
        grace_d   = grace_q;
        pulse_d   = pulse_q;

        if (wr_en && !lock_q) begin
            case (bus.address)
                ADDR_CTRL: begin
                    enable_d = wdata[0];
                    lock_d   = wdata[1];
                end
                ADDR_GRACE: grace_d = wdata[GRACE_W-1:0];
                ADDR_PULSE: pulse_d = wdata[PULSE_W-1:0];
                default: ;
            endcase
        end

        // ACK is applied first so that a same-cycle escalation set wins.
        if (ack) begin
            irq_d    = 1'b0;
            caused_d = 1'b0;
        end

        if (!enable_d) begin
            state_d   = IDLE;
            rst_req_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable_q && trig) begin
                    state_d = WARN;
                    gcnt_d  = grace_q;
                    irq_d   = 1'b1;
                end
                WARN: begin
                    if (!trig) begin
                        state_d = IDLE;
                    end else if (gcnt_q == '0) begin
                        state_d   = PULSE;
                        pcnt_d    = (pulse_q == '0) ? PULSE_W'(1) : pulse_q;
                        rst_req_d = 1'b1;
                        caused_d  = 1'b1;
                        if (events_q != '1) events_d = events_q + 1'b1;
                    end else begin
                        gcnt_d = gcnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (pcnt_q == PULSE_W'(1)) begin
                        state_d   = HOLD;
                        rst_req_d = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q - 1'b1;
                    end
                end
                HOLD: if (!trig) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gcnt_q    <= '0;
            pcnt_q    <= '0;
            events_q  <= '0;
            rst_req_q <= 1'b0;
            irq_q     <= 1'b0;
            caused_q  <= 1'b0;
            enable_q  <= 1'b0;
            lock_q    <= 1'b0;
            grace_q   <= '0;
            pulse_q   <= PULSE_W'(PULSE_DEFAULT);
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            pcnt_q    <= pcnt_d;
            events_q  <= events_d;
            rst_req_q <= rst_req_d;
            irq_q     <= irq_d;
            caused_q  <= caused_d;
            enable_q  <= enable_d;
            lock_q    <= lock_d;
            grace_q   <= grace_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        bus.data_ready = rd_en;
        bus.data_out   = '0;
        if (rd_en) begin
            case (bus.address)
                ADDR_CTRL:   bus.data_out = {30'd0, lock_q, enable_q};
                ADDR_GRACE:  bus.data_out = 32'(grace_q);
                ADDR_PULSE:  bus.data_out = 32'(pulse_q);
                ADDR_STATUS: bus.data_out = {23'd0, ext_fault, state_q, caused_q, irq_q,
                                             rst_req_q, lock_q, enable_q};
                ADDR_EVENTS: bus.data_out = 32'(events_q);
                default:     bus.data_out = '1;
            endcase
        end
    end

    assign uo_out         = {6'd0, rst_req_q, 1'b0};
    assign user_interrupt = irq_q;

endmodule

// File: tb/tb_tqvp_nkanderson_wdt_resetctl.sv
// Scoreboard bench for the watchdog escalation stage: directed scenarios plus random traffic,
// checked against a behavioural model of the escalation rules.
module tb_tqvp_nkanderson_wdt_resetctl;

`ifdef WDTRC_EXT_FAULT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       wdt_timeout;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic       user_interrupt;

    tqvp_nkanderson_wdt_resetctl_if bif ();

    tqvp_nkanderson_wdt_resetctl #(
        .GRACE_W       (16),
        .PULSE_W       (8),
        .PULSE_DEFAULT (16),
        .EVT_W         (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wdt_timeout    (wdt_timeout),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .user_interrupt (user_interrupt),
        .bus            (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] expq[$];

    // Reference model: phase 0 idle, 1 warning, 2 reset pulse, 3 hold; m_left counts cycles left.
    bit m_en, m_lock, m_irq, m_caused;
    int m_grace, m_pulse, m_events, m_phase, m_left;
    logic [7:0] ui_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_lock = 0; m_irq = 0; m_caused = 0;
        m_grace = 0; m_pulse = 16; m_events = 0; m_phase = 0; m_left = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] a, input logic ext_bit);
        case (a)
            6'd0:    return {30'd0, m_lock, m_en};
            6'd1:    return 32'(m_grace);
            6'd2:    return 32'(m_pulse);
            6'd4:    return {23'd0, ext_bit, 3'(m_phase), m_caused, m_irq, m_phase == 2, m_lock, m_en};
            6'd5:    return 32'(m_events);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_update(input logic to, input logic [7:0] ui, input logic [1:0] wr,
                                input logic [5:0] a, input logic [31:0] d);
        bit trig, new_en, new_lock;
        int new_grace, new_pulse;
        logic [31:0] wv;
        trig = to | (EXT & ui[6]);
        wv = (wr == 2'b00) ? (d & 32'hFF) : (wr == 2'b01) ? (d & 32'hFFFF) : d;
        new_en = m_en; new_lock = m_lock; new_grace = m_grace; new_pulse = m_pulse;
        if (wr != 2'b11 && !m_lock) begin
            if (a == 0) begin new_en = wv[0]; new_lock = wv[1]; end
            if (a == 1) new_grace = int'(wv & 32'hFFFF);
            if (a == 2) new_pulse = int'(wv & 32'hFF);
        end
        if (wr != 2'b11 && a == 3 && d == 32'h5A) begin
            m_irq = 0; m_caused = 0;
        end
        if (!new_en) m_phase = 0;
        else begin
            case (m_phase)
                0: if (m_en && trig) begin m_phase = 1; m_left = m_grace + 1; m_irq = 1; end
                1: if (!trig) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) begin
                           m_phase = 2;
                           m_left = (m_pulse == 0) ? 1 : m_pulse;
                           m_caused = 1;
                           if (m_events < 255) m_events++;
                       end
                   end
                2: begin m_left--; if (m_left == 0) m_phase = 3; end
                default: if (!trig) m_phase = 0;
            endcase
        end
        m_en = new_en; m_lock = new_lock; m_grace = new_grace; m_pulse = new_pulse;
    endtask

    task automatic tick(input logic to, input logic [7:0] ui, input logic [1:0] wr,
                        input logic [1:0] rd, input logic [5:0] a, input logic [31:0] d);
        wdt_timeout = to;
        ui_in = ui;
        bif.data_write_n = wr;
        bif.data_read_n = rd;
        bif.address = a;
        bif.data_in = d;
        if (rd != 2'b11) expq.push_back(exp_read(a, EXT & ui[6]));
        @(posedge clk);
        model_update(to, ui, wr, a, d);
        #1;
    endtask

    task automatic idle(input logic to);
        tick(to, ui_cur, 2'b11, 2'b11, 6'd0, 32'd0);
    endtask

    task automatic wr32(input logic to, input logic [5:0] a, input logic [31:0] d);
        tick(to, ui_cur, 2'b10, 2'b11, a, d);
    endtask

    task automatic rd32(input logic to, input logic [5:0] a);
        tick(to, ui_cur, 2'b11, 2'b10, a, 32'd0);
    endtask

    task automatic do_reset();
        bif.data_write_n = 2'b11;
        bif.data_read_n = 2'b11;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: per-cycle output check and scoreboard pop on every presented read.
    always @(negedge clk) begin
        chk("rst_req", {24'd0, uo_out}, {30'd0, m_phase == 2, 1'b0});
        chk("irq", {31'd0, user_interrupt}, {31'd0, m_irq});
        chk("data_ready", {31'd0, bif.data_ready}, {31'd0, bif.data_read_n != 2'b11});
        if (bif.data_ready) begin
            if (expq.size() == 0) chk("read_unexpected", bif.data_out, 32'hDEAD_BEEF);
            else chk("read_data", bif.data_out, expq.pop_front());
        end else begin
            chk("data_out_idle", bif.data_out, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic to;
        ui_cur = 8'd0;
        wdt_timeout = 1'b0;
        ui_in = 8'd0;
        bif.address = '0;
        bif.data_in = '0;
        do_reset();

        // Reset values of every readable register.
        for (int unsigned a = 0; a < 6; a++) rd32(0, 6'(a));

        // Full escalation: GRACE=3, PULSE=4, then hold and recovery.
        wr32(0, 6'd1, 32'd3);
        wr32(0, 6'd2, 32'd4);
        wr32(0, 6'd0, 32'd1);
        repeat (9) idle(1);
        rd32(1, 6'd5);
        rd32(1, 6'd4);
        repeat (3) idle(1);
        idle(0);
        rd32(0, 6'd4);

        // Recovery inside the grace window, then ACK key handling.
        wr32(0, 6'd3, 32'h5A);
        wr32(0, 6'd1, 32'd10);
        repeat (5) idle(1);
        repeat (3) idle(0);
        rd32(0, 6'd4);
        wr32(0, 6'd3, 32'h5B);
        rd32(0, 6'd4);
        wr32(0, 6'd3, 32'h5A);
        rd32(0, 6'd4);

        // Narrow writes zero-extend.
        tick(0, ui_cur, 2'b00, 2'b11, 6'd1, 32'hABCD_1207);
        rd32(0, 6'd1);
        tick(0, ui_cur, 2'b01, 2'b11, 6'd1, 32'hABCD_1207);
        rd32(0, 6'd1);

        // ACK in the same cycle as the IDLE->WARN step: set wins.
        wr32(0, 6'd1, 32'd2);
        wr32(1, 6'd3, 32'h5A);
        wr32(1, 6'd3, 32'h5A);
        rd32(0, 6'd4);

        // Lock freezes configuration but not ACK.
        wr32(0, 6'd0, 32'd3);
        wr32(0, 6'd0, 32'd0);
        wr32(0, 6'd1, 32'd99);
        rd32(0, 6'd0);
        rd32(0, 6'd1);
        wr32(0, 6'd3, 32'h5A);
        rd32(0, 6'd4);
        do_reset();

        // GRACE=0 / PULSE=0 gives one WARN cycle and a one-cycle pulse.
        wr32(0, 6'd1, 32'd0);
        wr32(0, 6'd2, 32'd0);
        wr32(0, 6'd0, 32'd1);
        repeat (5) idle(1);
        idle(0);
        // Disable mid-WARN: back to IDLE, no pulse.
        wr32(0, 6'd1, 32'd5);
        repeat (2) idle(1);
        wr32(1, 6'd0, 32'd0);
        repeat (8) idle(1);
        rd32(1, 6'd4);
        idle(0);

        // Saturating escalation count.
        wr32(0, 6'd1, 32'd0);
        wr32(0, 6'd2, 32'd1);
        wr32(0, 6'd0, 32'd1);
        for (int unsigned i = 0; i < 260; i++) begin
            repeat (3) idle(1);
            idle(0);
        end
        rd32(0, 6'd5);

        // Reset mid-pulse drops the request immediately.
        wr32(0, 6'd2, 32'd8);
        repeat (4) idle(1);
        chk("pulse_before_reset", {31'd0, uo_out[1]}, {31'd0, m_phase == 2});
        #2 rst_n = 1'b0;
        #1 chk("async_reset_drop", {24'd0, uo_out}, 32'd0);
        do_reset();

        // Unmapped and write-only reads.
        rd32(0, 6'd3);
        rd32(0, 6'd7);
        rd32(0, 6'd63);

`ifdef WDTRC_EXT_FAULT_EN
        // External fault pin escalates on its own.
        wr32(0, 6'd2, 32'd2);
        wr32(0, 6'd0, 32'd1);
        ui_cur = 8'h40;
        repeat (5) idle(0);
        rd32(0, 6'd4);
        ui_cur = 8'h00;
        idle(0);
        do_reset();
`endif

        // Random traffic.
        to = 1'b0;
        wr32(0, 6'd0, 32'd1);
        for (int unsigned i = 0; i < 3000; i++) begin
            int unsigned op;
            logic [1:0] sz;
            logic [31:0] d;
            if ($urandom_range(11) == 0) to = ~to;
            ui_cur = 8'($urandom) & (($urandom_range(7) == 0) ? 8'hFF : 8'hBF);
            op = $urandom_range(15);
            sz = 2'($urandom_range(2));
            if ($urandom_range(399) == 0) begin
                do_reset();
                wr32(to, 6'd0, 32'd1);
            end else if (op == 0) begin
                d = 32'($urandom_range(3));
                if (d[1] && $urandom_range(7) != 0) d[1] = 1'b0;
                if ($urandom_range(3) != 0) d[0] = 1'b1;
                tick(to, ui_cur, sz, 2'b11, 6'd0, d);
            end else if (op == 1 || op == 2) begin
                d = 32'($urandom_range(7));
                if (sz == 2'b00) d = d | ($urandom & 32'hFFFF_FF00);
                tick(to, ui_cur, sz, 2'b11, 6'(op), d);
            end else if (op == 3) begin
                d = ($urandom_range(1) == 0) ? 32'h5A : 32'($urandom);
                tick(to, ui_cur, 2'b10, 2'b11, 6'd3, d);
            end else if (op < 8) begin
                tick(to, ui_cur, 2'b11, sz, 6'($urandom_range(7)), 32'd0);
            end else begin
                tick(to, ui_cur, 2'b11, 2'b11, 6'd0, 32'd0);
            end
        end
        idle(0);
        idle(0);

        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
